// File: rtl/rr_mux_nt1.sv
// rr_mux_nt1: registered N:1 valid/ready selector, fixed-select or round-robin.
// Ports: CLK, RST_N, DIN/VALID_IN/READY_OUT (per channel), MODE, SEL,
//   DOUT/VALID_OUT/READY_IN/GRANT_IDX (output stage).
// Option RR_MUX_NT1_XFER_CNT_EN adds CNT_CLR and XFER_CNT[15:0].
module rr_mux_nt1 #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  input  logic [CHANNELS-1:0]       VALID_IN,
  output logic [CHANNELS-1:0]       READY_OUT,
  input  logic                      MODE,
  input  logic [SEL_W-1:0]          SEL,
  output logic [WIDTH-1:0]          DOUT,
  output logic                      VALID_OUT,
  input  logic                      READY_IN,
`ifdef RR_MUX_NT1_XFER_CNT_EN
  input  logic                      CNT_CLR,
  output logic [15:0]               XFER_CNT,
`endif
  output logic [SEL_W-1:0]          GRANT_IDX
);

  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                vld_q, vld_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic                free;
  logic                accept;
  logic                gnt_vld;
  logic [SEL_W-1:0]    gnt_idx;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    gnt_data;
  logic [SEL_W:0]      pos;

  // Nothing is offered upstream while reset is asserted.
  assign free   = RST_N & (~vld_q | READY_IN);
  assign accept = free & gnt_vld;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    if (!MODE) begin
      // Out-of-range SEL matches no channel.
      for (int i = 0; i < CHANNELS; i++) begin
        if (SEL == SEL_W'(i) && VALID_IN[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk from farthest to nearest so the
      // nearest valid after ptr wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        pos = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (pos >= (SEL_W+1)'(CHANNELS))
          pos = pos - (SEL_W+1)'(CHANNELS);
        if (VALID_IN[pos[SEL_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = pos[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_vld)
      grant[gnt_idx] = 1'b1;
  end

  assign READY_OUT = grant & {CHANNELS{free}};

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SEL_W'(i))
        gnt_data = DIN[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    dout_d = dout_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (accept) begin
      dout_d = gnt_data;
      idx_d  = gnt_idx;
      vld_d  = 1'b1;
      if (MODE)
        ptr_d = gnt_idx;
    end else if (free) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      ptr_q  <= SEL_W'(CHANNELS-1);
    end else begin
      dout_q <= dout_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign DOUT      = dout_q;
  assign VALID_OUT = vld_q;
  assign GRANT_IDX = idx_q;

`ifdef RR_MUX_NT1_XFER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR)
      cnt_d = '0;
    else if (vld_q & READY_IN)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign XFER_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_nt1.sv
// tb_rr_mux_nt1: directed bench for rr_mux_nt1 (8-channel and 5-channel).
// Covers reset, fixed sweep, round-robin, backpressure, bounds, counter.
module tb_rr_mux_nt1;

  logic        CLK;
  logic        RST_N;
  logic [255:0] din;
  logic [7:0]  vin;
  logic [7:0]  rdy_o;
  logic        mode;
  logic [2:0]  sel;
  logic [31:0] dout;
  logic        vout;
  logic        rdy_i;
  logic [2:0]  gidx;

  logic [159:0] din5;
  logic [4:0]  vin5;
  logic [4:0]  rdy5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [31:0] dout5;
  logic        vout5;
  logic [2:0]  gidx5;

`ifdef RR_MUX_NT1_XFER_CNT_EN
  logic        cnt_clr;
  logic [15:0] xcnt;
  logic        cnt_clr5;
  logic [15:0] xcnt5;
`endif

  int n_chk;
  int n_err;

  logic [31:0] dv [8];

  rr_mux_nt1 #(.WIDTH(32), .CHANNELS(8)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .DIN(din), .VALID_IN(vin), .READY_OUT(rdy_o),
    .MODE(mode), .SEL(sel),
    .DOUT(dout), .VALID_OUT(vout), .READY_IN(rdy_i),
`ifdef RR_MUX_NT1_XFER_CNT_EN
    .CNT_CLR(cnt_clr), .XFER_CNT(xcnt),
`endif
    .GRANT_IDX(gidx)
  );

  rr_mux_nt1 #(.WIDTH(32), .CHANNELS(5)) u_dut5 (
    .CLK(CLK), .RST_N(RST_N),
    .DIN(din5), .VALID_IN(vin5), .READY_OUT(rdy5),
    .MODE(mode5), .SEL(sel5),
    .DOUT(dout5), .VALID_OUT(vout5), .READY_IN(rdy_i),
`ifdef RR_MUX_NT1_XFER_CNT_EN
    .CNT_CLR(cnt_clr5), .XFER_CNT(xcnt5),
`endif
    .GRANT_IDX(gidx5)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int rr_seq [6];

  initial begin
    n_chk = 0;
    n_err = 0;
    dv[0] = 32'hABABABAB; dv[1] = 32'hAAAABBBB;
    dv[2] = 32'hACACACAC; dv[3] = 32'hAAAACCCC;
    dv[4] = 32'hBCBCBCBC; dv[5] = 32'hBBBBCCCC;
    dv[6] = 32'hDCDCDCDC; dv[7] = 32'hDDDDCCCC;
    for (int i = 0; i < 8; i++) din[i*32 +: 32] = dv[i];
    for (int i = 0; i < 5; i++) din5[i*32 +: 32] = dv[i];
    rr_seq[0] = 0; rr_seq[1] = 2; rr_seq[2] = 5;
    rr_seq[3] = 7; rr_seq[4] = 0; rr_seq[5] = 2;

    RST_N = 1'b0;
    vin   = 8'hFF;
    mode  = 1'b1;
    sel   = 3'd0;
    rdy_i = 1'b1;
    vin5  = 5'h00;
    mode5 = 1'b0;
    sel5  = 3'd0;
`ifdef RR_MUX_NT1_XFER_CNT_EN
    cnt_clr  = 1'b0;
    cnt_clr5 = 1'b0;
`endif

    // reset / idle
    #12;
    chk("rst_dout", dout, 32'h0);
    chk("rst_vout", {31'b0, vout}, 32'h0);
    chk("rst_gidx", {29'b0, gidx}, 32'h0);
    chk("rst_rdy", {24'b0, rdy_o}, 32'h0);
    step();
    RST_N = 1'b1;
    #1;
    chk("first_rdy", {24'b0, rdy_o}, 32'h01);
    step();
    chk("first_dout", dout, dv[0]);
    chk("first_gidx", {29'b0, gidx}, 32'd0);
    chk("first_vout", {31'b0, vout}, 32'd1);

    // fixed select sweep
    mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      chk("fix_rdy", {24'b0, rdy_o}, 32'h1 << s);
      step();
      chk("fix_dout", dout, dv[s]);
      chk("fix_gidx", {29'b0, gidx}, s);
    end

    // mid-transfer reset, then round-robin
    RST_N = 1'b0;
    #1;
    chk("rst_mid_vout", {31'b0, vout}, 32'd0);
    RST_N = 1'b1;
    vin  = 8'b1010_0101;
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_gidx", {29'b0, gidx}, rr_seq[k]);
      chk("rr_dout", dout, dv[rr_seq[k]]);
    end

    // backpressure
    mode = 1'b0;
    sel  = 3'd3;
    vin  = 8'hFF;
    step();
    chk("bp_load", dout, dv[3]);
    rdy_i = 1'b0;
    sel   = 3'd5;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_rdy", {24'b0, rdy_o}, 32'h0);
      step();
      chk("bp_dout", dout, dv[3]);
      chk("bp_gidx", {29'b0, gidx}, 32'd3);
      chk("bp_vout", {31'b0, vout}, 32'd1);
    end
    rdy_i = 1'b1;
    #1;
    chk("bp_rel_rdy", {24'b0, rdy_o}, 32'h20);
    step();
    chk("bp_next_dout", dout, dv[5]);
    chk("bp_next_gidx", {29'b0, gidx}, 32'd5);

    // 5-channel: out-of-range SEL
    vin5  = 5'h1F;
    mode5 = 1'b0;
    sel5  = 3'd1;
    step();
    chk("c5_vout", {31'b0, vout5}, 32'd1);
    chk("c5_dout", dout5, dv[1]);
    sel5 = 3'd6;
    #1;
    chk("c5_oor_rdy", {27'b0, rdy5}, 32'h0);
    step();
    chk("c5_oor_vout", {31'b0, vout5}, 32'd0);
    chk("c5_oor_dout", dout5, dv[1]);
    vin5 = 5'h00;

    // round-robin wrap onto the pointer itself
    mode = 1'b1;
    vin  = 8'h10;
    step();
    chk("wrap_gidx0", {29'b0, gidx}, 32'd4);
    #1;
    chk("wrap_rdy", {24'b0, rdy_o}, 32'h10);
    step();
    chk("wrap_gidx1", {29'b0, gidx}, 32'd4);
    chk("wrap_vout", {31'b0, vout}, 32'd1);

`ifdef RR_MUX_NT1_XFER_CNT_EN
    vin     = 8'hFF;
    cnt_clr = 1'b1;
    step();
    chk("cnt_clr_xfer", {16'b0, xcnt}, 32'd0);
    cnt_clr = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("cnt_3", {16'b0, xcnt}, 32'd3);
    rdy_i = 1'b0;
    step();
    chk("cnt_hold", {16'b0, xcnt}, 32'd3);
    rdy_i   = 1'b1;
    cnt_clr = 1'b1;
    step();
    chk("cnt_clr2", {16'b0, xcnt}, 32'd0);
    cnt_clr = 1'b0;
    repeat (65535) @(posedge CLK);
    #1;
    chk("cnt_ffff", {16'b0, xcnt}, 32'hFFFF);
    step();
    chk("cnt_wrap", {16'b0, xcnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
